// File: rtl/fft_source_capture.sv
`default_nettype none
// ============================================================================
//  Module   : fft_source_capture
//  Purpose  : Receive endpoint for the FFT core's Avalon-ST source port.
//             Checks SOP/EOP framing and the core error code, stores per-bin
//             power re^2+im^2 in a frame buffer and backpressures the core
//             until the downstream reader releases the held frame.
//  Revision : 1.0  initial release
// ============================================================================
module fft_source_capture #(
    parameter int DW  = 14,
    parameter int PTS = 1024,
    parameter int AW  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 source_valid,
    output logic                 source_ready,
    input  logic                 source_sop,
    input  logic                 source_eop,
    input  logic [1:0]           source_error,
    input  logic [DW-1:0]        source_real,
    input  logic [DW-1:0]        source_imag,
    input  logic [5:0]           source_exp,
    output logic                 frame_ready,
    output logic [5:0]           frame_exp,
    input  logic                 frame_done,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic [2*DW-1:0]      rd_data,
    output logic                 rd_valid,
    output logic [7:0]           err_count
);

    localparam logic [1:0]    S_IDLE    = 2'd0;
    localparam logic [1:0]    S_CAPTURE = 2'd1;
    localparam logic [1:0]    S_FLUSH   = 2'd2;
    localparam logic [1:0]    S_HOLD    = 2'd3;
    localparam int            c_PW      = 2 * DW;
    localparam logic [AW-1:0] c_LAST    = AW'(PTS - 1);
    localparam logic [AW-1:0] c_ONE     = AW'(1);

    logic [1:0]           r_state, w_state_nxt;
    logic [AW-1:0]        r_idx, w_idx_nxt;
    logic [5:0]           r_exp;
    logic                 w_beat, w_bad, w_last;
    logic                 w_push, w_cnt_inc, w_exp_load, w_frame_set, w_frame_clr;
    logic [AW-1:0]        w_push_addr;
    logic signed [c_PW-1:0] w_re_ext, w_im_ext, w_re_sq, w_im_sq;
    logic                 r_p1_valid;
    logic [AW-1:0]        r_p1_addr;
    logic [c_PW-1:0]      r_sq_re, r_sq_im, w_pwr;
    logic [c_PW-1:0]      r_mem [0:PTS-1];

    assign source_ready = ~reset & ((r_state == S_IDLE) | (r_state == S_CAPTURE));
    assign w_beat       = source_valid & source_ready;
    assign w_bad        = (source_error != 2'b00);
    assign w_last       = (r_idx == c_LAST);

    // Sign-extend to full product width so each square is exact.
    assign w_re_ext = {{DW{source_real[DW-1]}}, source_real};
    assign w_im_ext = {{DW{source_imag[DW-1]}}, source_imag};
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;
    // Sum of two squares peaks at 2^(2DW-1), so 2DW bits never overflow.
    assign w_pwr    = r_sq_re + r_sq_im;

    // Next-state, bin index and side-effect strobes for the capture FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_push      = 1'b0;
        w_push_addr = r_idx;
        w_cnt_inc   = 1'b0;
        w_exp_load  = 1'b0;
        w_frame_set = 1'b0;
        w_frame_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_beat && source_sop) begin
                    if (source_eop || w_bad) begin
                        w_cnt_inc = 1'b1;
                    end else begin
                        w_push      = 1'b1;
                        w_push_addr = '0;
                        w_exp_load  = 1'b1;
                        w_idx_nxt   = c_ONE;
                        w_state_nxt = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (w_beat) begin
                    if (w_bad) begin
                        w_cnt_inc   = 1'b1;
                        w_idx_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else if (source_sop) begin
                        // Count the broken frame, then restart on this beat.
                        w_cnt_inc   = 1'b1;
                        w_push      = 1'b1;
                        w_push_addr = '0;
                        w_exp_load  = 1'b1;
                        w_idx_nxt   = c_ONE;
                    end else if (w_last && source_eop) begin
                        w_push      = 1'b1;
                        w_idx_nxt   = '0;
                        w_state_nxt = S_FLUSH;
                    end else if (w_last != source_eop) begin
                        w_cnt_inc   = 1'b1;
                        w_idx_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_push      = 1'b1;
                        w_idx_nxt   = r_idx + c_ONE;
                    end
                end
            end
            S_FLUSH: begin
                w_frame_set = 1'b1;
                w_state_nxt = S_HOLD;
            end
            default: begin
                if (frame_done) begin
                    w_frame_clr = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // FSM state, index, exponent latch and frame/error status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_exp       <= '0;
            frame_ready <= 1'b0;
            frame_exp   <= '0;
            err_count   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_exp_load) begin
                r_exp <= source_exp;
            end
            if (w_frame_set) begin
                frame_ready <= 1'b1;
                frame_exp   <= r_exp;
            end else if (w_frame_clr) begin
                frame_ready <= 1'b0;
            end
            if (w_cnt_inc && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    // First write-pipeline stage: register squares and target bin.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p1_valid <= 1'b0;
            r_p1_addr  <= '0;
            r_sq_re    <= '0;
            r_sq_im    <= '0;
        end else begin
            r_p1_valid <= w_push;
            r_p1_addr  <= w_push_addr;
            r_sq_re    <= w_re_sq;
            r_sq_im    <= w_im_sq;
        end
    end

    // Second write-pipeline stage: commit power into the frame buffer.
    always_ff @(posedge clk) begin
        if (r_p1_valid) begin
            r_mem[r_p1_addr] <= w_pwr;
        end
    end

    // Registered read port, one cycle latency, available in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= r_mem[rd_addr];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_source_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_source_capture
//  Purpose  : Self-checking bench for fft_source_capture (PTS=16, DW=14).
//             A frame-level reference model predicts every output each cycle;
//             a few literal expectations pin the model to known numbers.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft_source_capture;

    localparam int DW  = 14;
    localparam int PTS = 16;
    localparam int AW  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            source_valid, source_sop, source_eop;
    logic            source_ready;
    logic [1:0]      source_error;
    logic [DW-1:0]   source_real, source_imag;
    logic [5:0]      source_exp;
    logic            frame_ready;
    logic [5:0]      frame_exp;
    logic            frame_done, rd_en;
    logic [AW-1:0]   rd_addr;
    logic [2*DW-1:0] rd_data;
    logic            rd_valid;
    logic [7:0]      err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int d_re [PTS];
    int d_im [PTS];

    fft_source_capture #(.DW(DW), .PTS(PTS), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .source_valid(source_valid), .source_ready(source_ready),
        .source_sop(source_sop), .source_eop(source_eop),
        .source_error(source_error), .source_real(source_real),
        .source_imag(source_imag), .source_exp(source_exp),
        .frame_ready(frame_ready), .frame_exp(frame_exp),
        .frame_done(frame_done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    localparam int M_IDLE = 0, M_CAP = 1, M_FLUSH = 2, M_HOLD = 3;
    int         m_mode = M_IDLE;
    bit         m_live = 1'b0;
    bit         m_fr = 1'b0, m_rdv = 1'b0, m_rd_chk = 1'b0;
    logic [5:0] m_fexp = '0, m_lexp = '0;
    int         m_err = 0;
    longint     m_rd_exp = 0;
    longint     m_cur [$];
    longint     m_buf [PTS];

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    always @(posedge clk) begin : p_model
        longint re, im, p;
        int     prev;
        m_live = 1'b1;
        if (reset) begin
            m_mode = M_IDLE; m_fr = 0; m_fexp = '0; m_err = 0;
            m_rdv = 0; m_rd_chk = 0; m_cur.delete();
        end else begin
            prev     = m_mode;
            m_rdv    = rd_en;
            m_rd_chk = rd_en && (prev == M_HOLD);
            if (rd_en) m_rd_exp = m_buf[rd_addr];
            re = longint'($signed(source_real));
            im = longint'($signed(source_imag));
            p  = re * re + im * im;
            if (prev == M_HOLD) begin
                if (frame_done) begin m_fr = 0; m_mode = M_IDLE; end
            end else if (prev == M_FLUSH) begin
                m_mode = M_HOLD; m_fr = 1; m_fexp = m_lexp;
                for (int i = 0; i < PTS; i++) m_buf[i] = m_cur[i];
            end else if (source_valid) begin
                if (prev == M_IDLE) begin
                    if (source_sop) begin
                        if (source_eop || source_error != 0) m_err = sat_inc(m_err);
                        else begin
                            m_cur.delete(); m_cur.push_back(p);
                            m_lexp = source_exp; m_mode = M_CAP;
                        end
                    end
                end else begin
                    if (source_error != 0) begin
                        m_err = sat_inc(m_err); m_mode = M_IDLE;
                    end else if (source_sop) begin
                        m_err = sat_inc(m_err);
                        m_cur.delete(); m_cur.push_back(p); m_lexp = source_exp;
                    end else if (m_cur.size() == PTS - 1 && source_eop) begin
                        m_cur.push_back(p); m_mode = M_FLUSH;
                    end else if ((m_cur.size() == PTS - 1) != source_eop) begin
                        m_err = sat_inc(m_err); m_mode = M_IDLE;
                    end else begin
                        m_cur.push_back(p);
                    end
                end
            end
        end
    end

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("source_ready", source_ready, (!reset && m_mode <= M_CAP));
            chk("frame_ready", frame_ready, m_fr);
            chk("frame_exp", frame_exp, m_fexp);
            chk("err_count", err_count, m_err);
            chk("rd_valid", rd_valid, m_rdv);
            if (m_rdv && m_rd_chk) chk("rd_data", rd_data, m_rd_exp);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < PTS; k++) begin d_re[k] = k; d_im[k] = -k; end
    endtask

    task automatic fill_const(input int re, input int im);
        for (int k = 0; k < PTS; k++) begin d_re[k] = re; d_im[k] = im; end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < PTS; k++) begin
            d_re[k] = int'($urandom_range(0, 16383)) - 8192;
            d_im[k] = int'($urandom_range(0, 16383)) - 8192;
        end
    endtask

    // Send n beats; sop_at restarts data indexing, err_at injects error code 01.
    task automatic send_frame(input int n, input int eop_at, input int sop_at,
                              input int err_at, input bit first_sop,
                              input logic [5:0] ex, input bit gaps);
        for (int k = 0; k < n; k++) begin
            int j;
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    source_valid = 1'b0;
                    cyc();
                end
            end
            j = (sop_at >= 0 && k >= sop_at) ? k - sop_at : k;
            source_valid = 1'b1;
            source_sop   = (first_sop && k == 0) || (k == sop_at);
            source_eop   = (k == eop_at);
            source_error = (k == err_at) ? 2'b01 : 2'b00;
            source_real  = DW'(d_re[j]);
            source_imag  = DW'(d_im[j]);
            source_exp   = ex;
            cyc();
        end
        source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0;
        source_error = 2'b00;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!frame_ready && n < 20) begin cyc(); n++; end
        chk(nm, frame_ready, 1);
    endtask

    task automatic rd_one(input string nm, input int addr, input longint exp);
        rd_en = 1'b1; rd_addr = AW'(addr);
        cyc();
        rd_en = 1'b0;
        chk(nm, rd_data, exp);
    endtask

    task automatic read_all();
        for (int a = 0; a < PTS; a++) begin
            rd_en = 1'b1; rd_addr = AW'(a);
            cyc();
        end
        rd_en = 1'b0;
        cyc();
    endtask

    task automatic release_frame();
        frame_done = 1'b1;
        cyc();
        frame_done = 1'b0;
        chk("released", frame_ready, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        reset = 1'b1; source_valid = 0; source_sop = 0; source_eop = 0;
        source_error = 0; source_real = 0; source_imag = 0; source_exp = 0;
        frame_done = 0; rd_en = 0; rd_addr = 0;
        repeat (3) cyc();
        chk("ready_in_reset", source_ready, 0);
        reset = 1'b0;
        cyc();
        chk("ready_after_reset", source_ready, 1);
        chk("err_after_reset", err_count, 0);
        chk("rd_data_after_reset", rd_data, 0);

        // Clean ramp frame at full rate.
        fill_ramp();
        send_frame(PTS, PTS - 1, -1, -1, 1'b1, 6'h3D, 1'b0);
        chk("ready_flush", frame_ready, 0);
        cyc();
        chk("frame_ready_eop+2", frame_ready, 1);
        chk("frame_exp_m3", frame_exp, 6'h3D);
        chk("hold_backpressure", source_ready, 0);
        rd_one("ramp_bin5", 5, 50);
        read_all();
        release_frame();

        // Most negative values on both parts, then max positive real.
        fill_const(-8192, -8192);
        send_frame(PTS, PTS - 1, -1, -1, 1'b1, 6'h00, 1'b0);
        wait_ready("wait_extreme_neg");
        rd_one("neg_bin0", 0, 64'h800_0000);
        rd_one("neg_bin15", 15, 64'h800_0000);
        release_frame();
        fill_const(8191, 0);
        send_frame(PTS, PTS - 1, -1, -1, 1'b1, 6'h05, 1'b1);
        wait_ready("wait_extreme_pos");
        rd_one("pos_bin7", 7, 67092481);
        release_frame();

        // Random data with gaps, then the same data at full rate.
        fill_rand();
        send_frame(PTS, PTS - 1, -1, -1, 1'b1, 6'h12, 1'b1);
        wait_ready("wait_gaps");
        read_all();
        release_frame();
        send_frame(PTS, PTS - 1, -1, -1, 1'b1, 6'h12, 1'b0);
        wait_ready("wait_full_rate");
        read_all();
        release_frame();

        // Framing errors.
        fill_ramp();
        send_frame(10, 9, -1, -1, 1'b1, 6'h01, 1'b0);
        cyc();
        chk("early_eop_err", err_count, 1);
        send_frame(PTS, -1, -1, -1, 1'b1, 6'h01, 1'b0);
        cyc();
        chk("missing_eop_err", err_count, 2);
        send_frame(6 + PTS, 6 + PTS - 1, 6, -1, 1'b1, 6'h2A, 1'b0);
        wait_ready("wait_sop_restart");
        chk("sop_restart_err", err_count, 3);
        chk("sop_restart_exp", frame_exp, 6'h2A);
        rd_one("sop_restart_bin5", 5, 50);
        read_all();
        release_frame();

        // Error code mid-frame, then stray non-SOP beats.
        send_frame(PTS, PTS - 1, -1, 3, 1'b1, 6'h01, 1'b0);
        repeat (4) cyc();
        chk("error_code_err", err_count, 4);
        chk("error_no_frame", frame_ready, 0);
        send_frame(5, -1, -1, -1, 1'b0, 6'h01, 1'b0);
        cyc();
        chk("nosop_ignored", err_count, 4);

        // Reset in the middle of a frame, then a fresh frame.
        send_frame(8, -1, -1, -1, 1'b1, 6'h01, 1'b0);
        reset = 1'b1;
        cyc();
        chk("midreset_err", err_count, 0);
        chk("midreset_ready", source_ready, 0);
        reset = 1'b0;
        frame_done = 1'b1;
        cyc();
        frame_done = 1'b0;
        fill_rand();
        send_frame(PTS, PTS - 1, -1, -1, 1'b1, 6'h3F, 1'b0);
        frame_done = 1'b1;
        cyc();
        frame_done = 1'b0;
        chk("done_in_flush_ignored", frame_ready, 1);
        read_all();
        release_frame();

        // Random frames, some with early EOP.
        for (int r = 0; r < 8; r++) begin
            int e;
            fill_rand();
            e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, PTS - 2)) : PTS - 1;
            send_frame(e + 1, e, -1, -1, 1'b1, 6'($urandom_range(0, 63)),
                       1'($urandom_range(0, 1)));
            if (e == PTS - 1) begin
                wait_ready("wait_random");
                read_all();
                release_frame();
            end else begin
                repeat (3) cyc();
            end
        end

        repeat (3) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
